// File: rtl/pdm_pkg.sv
// pdm_pkg: channel-mode constants, sequencer states and channel-count helper for the PDM front end
package pdm_pkg;

    localparam logic [1:0] PDM_MODE_1CH     = 2'b00;
    localparam logic [1:0] PDM_MODE_2CH_RF  = 2'b01;
    localparam logic [1:0] PDM_MODE_2CH_SEP = 2'b10;
    localparam logic [1:0] PDM_MODE_4CH     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISCARD,
        ST_RUN,
        ST_DRAIN
    } pdm_ctrl_state_e;

    function automatic logic [1:0] last_ch(input logic [1:0] mode);
        return (mode == PDM_MODE_2CH_RF || mode == PDM_MODE_2CH_SEP) ? 2'd1 :
               (mode == PDM_MODE_4CH) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/pdm_pack.sv
// pdm_pack: pairs consecutive PCM samples into one word, holds it for the DMA and flags lost words
module pdm_pack
    import pdm_pkg::*;
#(
    parameter int PCM_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               sample_i,
    input  logic               ovf_clr_i,
    input  logic [1:0]         ch_i,
    input  logic [PCM_W-1:0]   pcm_i,
    input  logic               ready_i,
    output logic [2*PCM_W-1:0] data_o,
    output logic [1:0]         data_ch_o,
    output logic               valid_o,
    output logic               overflow_o
);

    logic               phase_q, phase_d;
    logic [PCM_W-1:0]   low_q, low_d;
    logic [1:0]         tag_q, tag_d;
    logic [2*PCM_W-1:0] data_q, data_d;
    logic [1:0]         ch_q, ch_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               load, take;

    assign load = sample_i && phase_q && !clr_i;
    // a completed word is only accepted when the output slot is empty or draining this cycle
    assign take = load && (!valid_q || ready_i);

    always_comb begin
        phase_d = clr_i ? 1'b0 : sample_i ? ~phase_q : phase_q;
        low_d   = clr_i ? '0 : (sample_i && !phase_q) ? pcm_i : low_q;
        tag_d   = clr_i ? 2'd0 : (sample_i && !phase_q) ? ch_i : tag_q;
        data_d  = take ? {pcm_i, low_q} : data_q;
        ch_d    = take ? tag_q : ch_q;
        valid_d = take || (valid_q && !ready_i);
        ovf_d   = ovf_clr_i ? 1'b0 : (ovf_q || (load && valid_q && !ready_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            low_q   <= '0;
            tag_q   <= 2'd0;
            data_q  <= '0;
            ch_q    <= 2'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            low_q   <= low_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign data_ch_o  = ch_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pdm_ctrl.sv
// pdm_ctrl: run-control sequencer for the PDM front end with warm-up frame discard and PCM word packing
module pdm_ctrl
    import pdm_pkg::*;
#(
    parameter int PCM_W     = 16,
    parameter int DISCARD_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_start_i,
    input  logic                 cfg_stop_i,
    input  logic [1:0]           cfg_ch_mode_i,
    input  logic [9:0]           cfg_decimation_i,
    input  logic [2:0]           cfg_shift_i,
    input  logic [DISCARD_W-1:0] cfg_discard_i,
    output logic                 pdm_en_o,
    output logic                 pdm_update_o,
    output logic [1:0]           pdm_ch_mode_o,
    output logic [9:0]           pdm_decimation_o,
    output logic [2:0]           pdm_shift_o,
    input  logic [PCM_W-1:0]     pcm_data_i,
    input  logic                 pcm_valid_i,
    output logic [2*PCM_W-1:0]   data_o,
    output logic [1:0]           data_ch_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 busy_o,
    output logic                 overflow_o
);

    pdm_ctrl_state_e      state_q;
    logic [1:0]           mode_q;
    logic [9:0]           dec_q;
    logic [2:0]           shift_q;
    logic [DISCARD_W-1:0] disc_q;
    logic [DISCARD_W-1:0] frame_q;
    logic [1:0]           ch_q;
    logic                 en_q;
    logic                 upd_q;
    logic                 wrap;
    logic                 go;

    assign wrap = ch_q == last_ch(mode_q);
    assign go   = state_q == ST_IDLE && cfg_start_i && !cfg_stop_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            dec_q   <= 10'd0;
            shift_q <= 3'd0;
            disc_q  <= '0;
            frame_q <= '0;
            ch_q    <= 2'd0;
            en_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (go) begin
                    mode_q  <= cfg_ch_mode_i;
                    dec_q   <= cfg_decimation_i;
                    shift_q <= cfg_shift_i;
                    disc_q  <= cfg_discard_i;
                    en_q    <= 1'b1;
                    upd_q   <= 1'b1;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    ch_q    <= 2'd0;
                    frame_q <= '0;
                    en_q    <= !cfg_stop_i;
                    state_q <= cfg_stop_i ? ST_IDLE : (disc_q == '0) ? ST_RUN : ST_DISCARD;
                end
                ST_DISCARD: if (cfg_stop_i) begin
                    en_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end else if (pcm_valid_i) begin
                    ch_q <= wrap ? 2'd0 : ch_q + 2'd1;
                    if (wrap) begin
                        frame_q <= DISCARD_W'(frame_q + 1'b1);
                        if (DISCARD_W'(frame_q + 1'b1) == disc_q) state_q <= ST_RUN;
                    end
                end
                ST_RUN: if (cfg_stop_i) begin
                    en_q    <= 1'b0;
                    state_q <= ST_DRAIN;
                end else if (pcm_valid_i) begin
                    ch_q <= wrap ? 2'd0 : ch_q + 2'd1;
                end
                ST_DRAIN: if (!data_valid_o) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pdm_pack #(.PCM_W(PCM_W)) u_pack (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (state_q == ST_LOAD),
        .sample_i   (state_q == ST_RUN && pcm_valid_i && !cfg_stop_i),
        .ovf_clr_i  (go),
        .ch_i       (ch_q),
        .pcm_i      (pcm_data_i),
        .ready_i    (data_ready_i),
        .data_o     (data_o),
        .data_ch_o  (data_ch_o),
        .valid_o    (data_valid_o),
        .overflow_o (overflow_o)
    );

    assign pdm_en_o         = en_q;
    assign pdm_update_o     = upd_q;
    assign pdm_ch_mode_o    = mode_q;
    assign pdm_decimation_o = dec_q;
    assign pdm_shift_o      = shift_q;
    assign busy_o           = state_q != ST_IDLE;

endmodule

// File: tb/tb_pdm_ctrl.sv
// tb_pdm_ctrl: directed scenario tests for the PDM run-control sequencer and packer
module tb_pdm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [9:0]  dec = 10'd0;
    logic [2:0]  shift = 3'd0;
    logic [3:0]  disc = 4'd0;
    logic        en, upd;
    logic [1:0]  mode_o;
    logic [9:0]  dec_o;
    logic [2:0]  shift_o;
    logic [15:0] pcm = 16'd0;
    logic        pcm_v = 1'b0;
    logic [31:0] data;
    logic [1:0]  data_ch;
    logic        dv;
    logic        ready = 1'b1;
    logic        busy, ovf;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    pdm_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_start_i      (start),
        .cfg_stop_i       (stop),
        .cfg_ch_mode_i    (mode),
        .cfg_decimation_i (dec),
        .cfg_shift_i      (shift),
        .cfg_discard_i    (disc),
        .pdm_en_o         (en),
        .pdm_update_o     (upd),
        .pdm_ch_mode_o    (mode_o),
        .pdm_decimation_o (dec_o),
        .pdm_shift_o      (shift_o),
        .pcm_data_i       (pcm),
        .pcm_valid_i      (pcm_v),
        .data_o           (data),
        .data_ch_o        (data_ch),
        .data_valid_o     (dv),
        .data_ready_i     (ready),
        .busy_o           (busy),
        .overflow_o       (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [3:0] d);
        mode = m;
        disc = d;
        dec = 10'd100;
        shift = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        pcm = v;
        pcm_v = 1'b1;
        tick();
        pcm_v = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if ({en, upd, mode_o, dec_o, shift_o, data, data_ch, dv, busy, ovf} !== '0) begin
            $display("FAIL reset_outputs got=%h exp=0", {en, upd, mode_o, dec_o, shift_o, data, data_ch, dv, busy, ovf});
        end else passed++;
        total++;
        rst = 1'b0;
        tick();
        if (busy !== 1'b0 || en !== 1'b0) begin
            $display("FAIL reset_idle busy=%b en=%b exp 0 0", busy, en);
        end else passed++;
        total++;
    endtask

    task automatic test_4ch_discard();
        logic [31:0] ew;
        logic [1:0]  ec;
        start_run(2'b11, 4'd2);
        if (en !== 1'b1 || upd !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL load_strobe en=%b upd=%b busy=%b exp 1 1 1", en, upd, busy);
        end else passed++;
        total++;
        if (mode_o !== 2'b11 || dec_o !== 10'd100 || shift_o !== 3'd2) begin
            $display("FAIL shadow_cfg mode=%b dec=%0d shift=%0d exp 11 100 2", mode_o, dec_o, shift_o);
        end else passed++;
        total++;
        tick();
        if (en !== 1'b1 || upd !== 1'b0) begin
            $display("FAIL update_one_cycle en=%b upd=%b exp 1 0", en, upd);
        end else passed++;
        total++;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i));
            if (i > 8 && i % 2 == 0) begin
                ew = {16'(i), 16'(i - 1)};
                ec = (i == 10 || i == 14) ? 2'd0 : 2'd2;
                if (dv !== 1'b1 || data !== ew || data_ch !== ec) begin
                    $display("FAIL word4ch_%0d dv=%b data=%h ch=%0d exp 1 %h %0d", i, dv, data, data_ch, ew, ec);
                end else passed++;
                total++;
            end else begin
                if (dv !== 1'b0) begin
                    $display("FAIL novalid4ch_%0d dv=%b exp 0", i, dv);
                end else passed++;
                total++;
            end
        end
        do_stop();
        tick();
        if (busy !== 1'b0 || en !== 1'b0) begin
            $display("FAIL stop4ch_idle busy=%b en=%b exp 0 0", busy, en);
        end else passed++;
        total++;
    endtask

    task automatic test_1ch_stop();
        start_run(2'b00, 4'd0);
        tick();
        dec = 10'd5;
        send(16'h1111);
        if (dv !== 1'b0) begin
            $display("FAIL word1ch_early dv=%b exp 0", dv);
        end else passed++;
        total++;
        send(16'h2222);
        if (dv !== 1'b1 || data !== 32'h22221111 || data_ch !== 2'd0) begin
            $display("FAIL word1ch dv=%b data=%h ch=%0d exp 1 22221111 0", dv, data, data_ch);
        end else passed++;
        total++;
        if (dec_o !== 10'd100) begin
            $display("FAIL dec_stable dec=%0d exp 100", dec_o);
        end else passed++;
        total++;
        send(16'h3333);
        do_stop();
        if (en !== 1'b0 || busy !== 1'b1 || dv !== 1'b0) begin
            $display("FAIL drain1ch en=%b busy=%b dv=%b exp 0 1 0", en, busy, dv);
        end else passed++;
        total++;
        tick();
        if (busy !== 1'b0 || dv !== 1'b0) begin
            $display("FAIL idle1ch busy=%b dv=%b exp 0 0", busy, dv);
        end else passed++;
        total++;
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        start_run(2'b10, 4'd0);
        tick();
        send(16'hA000);
        send(16'hA001);
        send(16'hB000);
        send(16'hB001);
        if (ovf !== 1'b1 || dv !== 1'b1 || data !== 32'hA001A000) begin
            $display("FAIL ovf_set ovf=%b dv=%b data=%h exp 1 1 a001a000", ovf, dv, data);
        end else passed++;
        total++;
        ready = 1'b1;
        tick();
        if (dv !== 1'b0 || ovf !== 1'b1) begin
            $display("FAIL ovf_first_only dv=%b ovf=%b exp 0 1", dv, ovf);
        end else passed++;
        total++;
        do_stop();
        tick();
        start_run(2'b10, 4'd0);
        if (ovf !== 1'b0 || mode_o !== 2'b10) begin
            $display("FAIL ovf_clear ovf=%b mode=%b exp 0 10", ovf, mode_o);
        end else passed++;
        total++;
        do_stop();
        tick();
    endtask

    task automatic test_drain_wait();
        ready = 1'b0;
        start_run(2'b01, 4'd0);
        tick();
        send(16'h0C00);
        send(16'h0C01);
        do_stop();
        tick();
        tick();
        if (busy !== 1'b1 || dv !== 1'b1 || en !== 1'b0) begin
            $display("FAIL drain_hold busy=%b dv=%b en=%b exp 1 1 0", busy, dv, en);
        end else passed++;
        total++;
        ready = 1'b1;
        tick();
        if (dv !== 1'b0) begin
            $display("FAIL drain_xfer dv=%b exp 0", dv);
        end else passed++;
        total++;
        tick();
        if (busy !== 1'b0) begin
            $display("FAIL drain_idle busy=%b exp 0", busy);
        end else passed++;
        total++;
    endtask

    task automatic test_rst_mid_run();
        ready = 1'b0;
        start_run(2'b01, 4'd0);
        tick();
        for (int i = 0; i < 4; i++) send(16'(i + 5));
        if (ovf !== 1'b1 || dv !== 1'b1) begin
            $display("FAIL pre_rst ovf=%b dv=%b exp 1 1", ovf, dv);
        end else passed++;
        total++;
        rst = 1'b1;
        tick();
        if ({en, upd, mode_o, dec_o, shift_o, data, data_ch, dv, busy, ovf} !== '0) begin
            $display("FAIL rst_mid_run got=%h exp=0", {en, upd, mode_o, dec_o, shift_o, data, data_ch, dv, busy, ovf});
        end else passed++;
        total++;
        rst = 1'b0;
        ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_4ch_discard();
        test_1ch_stop();
        test_overflow();
        test_drain_wait();
        test_rst_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
